// File: rtl/fp_mul_iter.sv
// Multi-cycle FP16 (1/5/10) multiplier: shift-add mantissa product, BITS_PER_CYCLE
// multiplier bits per cycle, truncating normalise, flush-to-zero and saturate-to-inf.
module fp_mul_iter #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy
);
    localparam int unsigned MW  = 11;
    localparam int unsigned PW  = 22;
    localparam int unsigned B   = BITS_PER_CYCLE;
    localparam int unsigned N   = (MW + B - 1) / B;
    localparam int unsigned MBW = N * B;
    localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_sign;
    logic [5:0]       r_esum;
    logic [PW-1:0]    r_ma_sh;
    logic [MBW-1:0]   r_mb;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic [15:0]      r_product;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_busy;

    logic             w_zero_in;
    logic             w_last;
    logic [PW-1:0]    w_pp;
    logic [PW-1:0]    w_sum;
    logic             w_norm_hi;
    logic [9:0]       w_mant;
    logic [6:0]       w_esum;
    logic [15:0]      w_prod_mul;
    logic             w_in_ready_next;
    logic             w_busy_next;
    logic             w_out_valid_next;

    assign w_zero_in = (opA[14:0] == 15'd0) || (opB[14:0] == 15'd0);
    assign w_last    = (r_cnt == CW'(N - 1));

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = w_zero_in ? S_DONE : S_MUL;
            S_MUL:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they track r_state exactly.
    always_comb begin
        w_in_ready_next  = (w_state_next == S_IDLE);
        w_busy_next      = (w_state_next != S_IDLE);
        w_out_valid_next = (w_state_next == S_DONE);
    end

    // Partial product of the next multiplier slice; arithmetic mod 2^22 is exact
    // because every partial sum is bounded by the final 22-bit product.
    always_comb begin
        w_pp       = PW'(r_ma_sh * PW'(r_mb[B-1:0]));
        w_sum      = r_acc + w_pp;
        w_norm_hi  = w_sum[21];
        w_mant     = w_norm_hi ? w_sum[20:11] : w_sum[19:10];
        w_esum     = 7'(r_esum) + 7'(w_norm_hi);
        if (w_esum <= 7'd15)
            w_prod_mul = {r_sign, 15'd0};
        else if (w_esum >= 7'd46)
            w_prod_mul = {r_sign, 5'h1F, 10'd0};
        else
            w_prod_mul = {r_sign, 5'(w_esum - 7'd15), w_mant};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_product   <= 16'h0000;
            r_sign      <= 1'b0;
            r_esum      <= 6'd0;
            r_ma_sh     <= '0;
            r_mb        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            r_in_ready  <= w_in_ready_next;
            r_busy      <= w_busy_next;
            r_out_valid <= w_out_valid_next;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign  <= opA[15] ^ opB[15];
                        r_esum  <= 6'(opA[14:10]) + 6'(opB[14:10]);
                        r_ma_sh <= PW'({1'b1, opA[9:0]});
                        r_mb    <= MBW'({1'b1, opB[9:0]});
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        if (w_zero_in) r_product <= {opA[15] ^ opB[15], 15'd0};
                    end
                end
                S_MUL: begin
                    r_acc   <= w_sum;
                    r_cnt   <= r_cnt + CW'(1);
                    r_ma_sh <= r_ma_sh << B;
                    r_mb    <= r_mb >> B;
                    if (w_last) r_product <= w_prod_mul;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign product   = r_product;
endmodule

// File: tb/tb_fp_mul_iter.sv
// Bench for fp_mul_iter: one instance with 1 bit/cycle and one with 11 bits/cycle,
// table vectors plus backpressure, reset-abort and random cases against a golden model.
module tb_fp_mul_iter;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid1, in_valid11;
    logic        in_ready1, in_ready11;
    logic [15:0] opA, opB;
    logic        out_valid1, out_valid11;
    logic        out_ready;
    logic [15:0] product1, product11;
    logic        busy1, busy11;

    logic        sel;
    logic        m_ready, m_valid, m_busy;
    logic [15:0] m_prod;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] sb_q[$];

    always #5 clock = ~clock;

    fp_mul_iter #(.BITS_PER_CYCLE(1)) u_dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .opA(opA), .opB(opB), .out_valid(out_valid1), .out_ready(out_ready),
        .product(product1), .busy(busy1)
    );

    fp_mul_iter #(.BITS_PER_CYCLE(11)) u_dut11 (
        .clock(clock), .reset(reset), .in_valid(in_valid11), .in_ready(in_ready11),
        .opA(opA), .opB(opB), .out_valid(out_valid11), .out_ready(out_ready),
        .product(product11), .busy(busy11)
    );

    always_comb begin
        m_ready = sel ? in_ready11  : in_ready1;
        m_valid = sel ? out_valid11 : out_valid1;
        m_busy  = sel ? busy11      : busy1;
        m_prod  = sel ? product11   : product1;
    end

    typedef struct {
        bit          sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
    } vec_t;

    function automatic logic [15:0] gold(input logic [15:0] a, input logic [15:0] b);
        logic       s;
        int         p, e, adj;
        logic [9:0] m;
        logic [4:0] e5;
        s = a[15] ^ b[15];
        if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return {s, 15'd0};
        p   = (1024 + int'(a[9:0])) * (1024 + int'(b[9:0]));
        adj = (p >= 32'h0020_0000) ? 1 : 0;
        m   = 10'((adj == 1) ? (p >>> 11) : (p >>> 10));
        e   = int'(a[14:10]) + int'(b[14:10]) + adj - 15;
        if (e <= 0)  return {s, 15'd0};
        if (e >= 31) return {s, 5'h1F, 10'd0};
        e5 = 5'(e);
        return {s, e5, m};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic drive_valid(input logic v);
        if (sel) in_valid11 = v;
        else     in_valid1  = v;
    endtask

    task automatic accept(input logic [15:0] a, input logic [15:0] b, input string tag);
        int w;
        w = 0;
        while (!m_ready && w < 40) begin
            @(posedge clock); #1; w++;
        end
        check({tag, "_rdy"}, int'(m_ready), 1);
        opA = a;
        opB = b;
        drive_valid(1'b1);
        @(posedge clock); #1;
        drive_valid(1'b0);
    endtask

    // Edges after the accept edge until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!m_valid && lat < 40) begin
            @(posedge clock); #1; lat++;
        end
    endtask

    task automatic do_op(input bit s, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_p, input int exp_lat, input string tag);
        int lat;
        sel = s;
        accept(a, b, tag);
        sb_q.push_back(exp_p);
        wait_out(lat);
        check({tag, "_lat"}, lat, exp_lat);
        if (m_valid) check({tag, "_prod"}, int'(m_prod), int'(sb_q.pop_front()));
        else         void'(sb_q.pop_front());
        @(posedge clock); #1;
        check({tag, "_ovdrop"}, int'(m_valid), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[13];
        int   lat;
        int   exp_lat;
        logic [15:0] ra, rb, hold_p;

        tbl[0]  = '{1'b0, 16'h3C00, 16'h3C00, 16'h3C00};
        tbl[1]  = '{1'b0, 16'h3E00, 16'h3E00, 16'h4080};
        tbl[2]  = '{1'b0, 16'hC000, 16'h4200, 16'hC600};
        tbl[3]  = '{1'b0, 16'h0000, 16'h4200, 16'h0000};
        tbl[4]  = '{1'b0, 16'h8000, 16'h4200, 16'h8000};
        tbl[5]  = '{1'b0, 16'h4200, 16'h8000, 16'h8000};
        tbl[6]  = '{1'b0, 16'h7800, 16'h7800, 16'h7C00};
        tbl[7]  = '{1'b0, 16'hF800, 16'h7800, 16'hFC00};
        tbl[8]  = '{1'b0, 16'h0400, 16'h0400, 16'h0000};
        tbl[9]  = '{1'b0, 16'h0400, 16'h8400, 16'h8000};
        tbl[10] = '{1'b1, 16'h3C00, 16'h3C00, 16'h3C00};
        tbl[11] = '{1'b1, 16'h3E00, 16'h3E00, 16'h4080};
        tbl[12] = '{1'b1, 16'hC000, 16'h4200, 16'hC600};

        reset = 1'b1; in_valid1 = 1'b0; in_valid11 = 1'b0;
        opA = 16'h0; opB = 16'h0; out_ready = 1'b1; sel = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ov1",   int'(out_valid1),  0);
        check("rst_prod1", int'(product1),    0);
        check("rst_busy1", int'(busy1),       0);
        check("rst_rdy1",  int'(in_ready1),   1);
        check("rst_ov11",  int'(out_valid11), 0);
        check("rst_rdy11", int'(in_ready11),  1);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].a[14:0] == 15'd0 || tbl[i].b[14:0] == 15'd0) exp_lat = 0;
            else exp_lat = tbl[i].sel ? 1 : 11;
            do_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].p, exp_lat, $sformatf("vec%0d", i));
        end

        // Backpressure: hold DONE five cycles and try to sneak in a new operation.
        sel = 1'b0;
        out_ready = 1'b0;
        accept(16'h3E00, 16'h3E00, "bp");
        sb_q.push_back(16'h4080);
        wait_out(lat);
        check("bp_lat", lat, 11);
        hold_p = sb_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_prod%0d", k), int'(m_prod),  int'(hold_p));
            check($sformatf("bp_ov%0d", k),   int'(m_valid), 1);
            check($sformatf("bp_rdy%0d", k),  int'(m_ready), 0);
            if (k == 1) begin
                opA = 16'h4000; opB = 16'h4000;
                drive_valid(1'b1);
            end
            @(posedge clock); #1;
            drive_valid(1'b0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_release_ov",  int'(m_valid), 0);
        check("bp_release_rdy", int'(m_ready), 1);
        @(posedge clock); #1;
        check("bp_nodrop_busy", int'(m_busy),  0);
        check("bp_nodrop_ov",   int'(m_valid), 0);
        check("bp_nodrop_prod", int'(m_prod),  16'h4080);
        do_op(1'b0, 16'h4000, 16'h4000, 16'h4400, 11, "bp_next");

        // Reset during the fourth MUL cycle aborts the operation.
        sel = 1'b0;
        accept(16'h3E00, 16'h3E00, "rstmid");
        repeat (3) @(posedge clock);
        #1;
        check("rstmid_busy_pre", int'(m_busy), 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rstmid_ov",   int'(m_valid), 0);
        check("rstmid_prod", int'(m_prod),  0);
        check("rstmid_busy", int'(m_busy),  0);
        check("rstmid_rdy",  int'(m_ready), 1);
        do_op(1'b0, 16'h4000, 16'h4000, 16'h4400, 11, "rstmid_next");

        // Random normal operands on both widths.
        for (int i = 0; i < 16; i++) begin
            ra = {1'($urandom), 5'($urandom_range(30, 1)), 10'($urandom)};
            rb = {1'($urandom), 5'($urandom_range(30, 1)), 10'($urandom)};
            do_op(1'(i % 2), ra, rb, gold(ra, rb), (i % 2 == 1) ? 1 : 11,
                  $sformatf("rnd%0d_%h_%h", i, ra, rb));
        end

        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
